// File: rtl/rf_wb_pkg.sv
// Shared types and default geometry for the register-file writeback collector.
// The lane buffers carry wb_entry_t, so every block sees one definition of an entry.
package rf_wb_pkg;

    localparam int ADDR_W     = 5;
    localparam int WORD_W     = 32;
    localparam int NUM_LANES  = 4;
    localparam int LANE_DEPTH = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wb_entry_t;

    // Two buffered results collide when they target the same register.
    function automatic logic same_dest(input wb_entry_t a, input wb_entry_t b);
        return a.addr == b.addr;
    endfunction

endpackage

// File: rtl/rf_wb_lane_fifo.sv
// Per-lane circular result buffer: head/tail pointers plus an occupancy count.
// Push and pop may happen in the same cycle; flush empties the buffer.
module rf_wb_lane_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = LANE_DEPTH
) (
    input  logic      clk,
    input  logic      arst,
    input  logic      flush,
    input  logic      push,
    input  wb_entry_t entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      empty,
    output logic      full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     head_ptr;
    logic [PW-1:0]     tail_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[head_ptr];

    // NOTE: storage is not reset; only the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_ptr] <= entry;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Writeback collector: buffers results from the execution lanes and drives the
// register-file write ports, letting an older lane win same-destination conflicts.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int WORD_WIDTH    = WORD_W,
    parameter int LANES         = NUM_LANES,
    parameter int DEPTH         = LANE_DEPTH
) (
    input  logic                                 clk_i,
    input  logic                                 arst_i,
    input  logic                                 flush_i,
    input  logic [LANES-1:0]                     valid_i,
    output logic [LANES-1:0]                     ready_o,
    input  logic [LANES-1:0][ADDRESS_WIDTH-1:0]  addr_i,
    input  logic [LANES-1:0][WORD_WIDTH-1:0]     data_i,
    output logic [LANES-1:0][ADDRESS_WIDTH-1:0]  select_r_o,
    output logic [LANES-1:0][WORD_WIDTH-1:0]     data_o,
    output logic [LANES-1:0]                     enable_writing_o,
    output logic [LANES-1:0]                     pending_o
);

    wb_entry_t          in_entry [LANES];
    wb_entry_t          head     [LANES];
    logic [LANES-1:0]   empty;
    logic [LANES-1:0]   full;
    logic [LANES-1:0]   grant;

    // ready depends on occupancy and flush only, never on valid_i.
    assign ready_o   = ~full & {LANES{~flush_i}};
    assign pending_o = ~empty | enable_writing_o;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign in_entry[i] = '{addr: addr_i[i], data: data_i[i]};

        rf_wb_lane_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk_i),
            .arst  (arst_i),
            .flush (flush_i),
            .push  (valid_i[i] && ready_o[i]),
            .entry (in_entry[i]),
            .pop   (grant[i]),
            .head  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // A head writes unless an older lane holds a head for the same register.
    // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
    always_comb begin
        grant = '0;
        for (int i = 0; i < LANES; i++) begin
            grant[i] = !empty[i];
            for (int j = 0; j < i; j++) begin
                if (!empty[j] && same_dest(head[j], head[i])) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    // Idle lanes keep their last address/data; only the enable drops.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            enable_writing_o <= '0;
            select_r_o       <= '0;
            data_o           <= '0;
        end else if (flush_i) begin
            enable_writing_o <= '0;
        end else begin
            enable_writing_o <= grant;
            for (int i = 0; i < LANES; i++) begin
                if (grant[i]) begin
                    select_r_o[i] <= head[i].addr;
                    data_o[i]     <= head[i].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based model of the writeback rules.
module tb_rf_writeback;

    localparam int AW = 5;
    localparam int WW = 32;
    localparam int L  = 4;
    localparam int D  = 2;
    localparam int EW = AW + WW;
    localparam int SW = 2 * L + L * AW + L * WW;

    logic                clk_i   = 1'b0;
    logic                arst_i  = 1'b0;
    logic                flush_i = 1'b0;
    logic [L-1:0]        valid_i = '0;
    logic [L-1:0]        ready_o;
    logic [L-1:0][AW-1:0] addr_i = '0;
    logic [L-1:0][WW-1:0] data_i = '0;
    logic [L-1:0][AW-1:0] select_r_o;
    logic [L-1:0][WW-1:0] data_o;
    logic [L-1:0]        enable_writing_o;
    logic [L-1:0]        pending_o;

    int tests_run    = 0;
    int tests_failed = 0;

    rf_writeback #(
        .ADDRESS_WIDTH (AW),
        .WORD_WIDTH    (WW),
        .LANES         (L),
        .DEPTH         (D)
    ) dut (
        .clk_i            (clk_i),
        .arst_i           (arst_i),
        .flush_i          (flush_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .addr_i           (addr_i),
        .data_i           (data_i),
        .select_r_o       (select_r_o),
        .data_o           (data_o),
        .enable_writing_o (enable_writing_o),
        .pending_o        (pending_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file fed by the DUT write ports, plus a per-lane log of committed data.
    logic [WW-1:0] rf [32] = '{default: 32'hDEAD_BEEF};
    logic [WW-1:0] wlog [L][$];

    always @(posedge clk_i) begin
        for (int i = 0; i < L; i++) begin
            if (enable_writing_o[i]) begin
                rf[select_r_o[i]] = data_o[i];
                wlog[i].push_back(data_o[i]);
            end
        end
    end

    // Reference model: one FIFO queue per lane and the expected write-port registers.
    logic [EW-1:0]        mq [L][$];
    logic [L-1:0]         m_en;
    logic [L-1:0][AW-1:0] m_sel;
    logic [L-1:0][WW-1:0] m_data;

    task automatic model_clear();
        for (int i = 0; i < L; i++) mq[i].delete();
        m_en   = '0;
        m_sel  = '0;
        m_data = '0;
    endtask

    function automatic logic [SW-1:0] dut_state();
        return {enable_writing_o, pending_o, select_r_o, data_o};
    endfunction

    function automatic logic [SW-1:0] exp_state();
        logic [L-1:0] p;
        for (int i = 0; i < L; i++) p[i] = (mq[i].size() != 0) || m_en[i];
        return {m_en, p, m_sel, m_data};
    endfunction

    // Drive one cycle of inputs, advance past the edge and update the model.
    task automatic run_cycle(input logic [L-1:0] v, input logic [L-1:0][AW-1:0] a,
                             input logic [L-1:0][WW-1:0] d, input logic f,
                             output logic [L-1:0] got_rdy, output logic [L-1:0] exp_rdy);
        logic [L-1:0]  g;
        logic [EW-1:0] hi;
        logic [EW-1:0] hj;
        valid_i = v;
        addr_i  = a;
        data_i  = d;
        flush_i = f;
        #1;
        got_rdy = ready_o;
        for (int i = 0; i < L; i++) exp_rdy[i] = !f && (mq[i].size() < D);
        for (int i = 0; i < L; i++) begin
            g[i] = mq[i].size() != 0;
            if (g[i]) begin
                hi = mq[i][0];
                for (int j = 0; j < i; j++) begin
                    if (mq[j].size() != 0) begin
                        hj = mq[j][0];
                        if (hj[EW-1:WW] == hi[EW-1:WW]) g[i] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk_i);
        if (f) begin
            for (int i = 0; i < L; i++) mq[i].delete();
            m_en = '0;
        end else begin
            for (int i = 0; i < L; i++) begin
                m_en[i] = g[i];
                if (g[i]) begin
                    hi        = mq[i].pop_front();
                    m_sel[i]  = hi[EW-1:WW];
                    m_data[i] = hi[WW-1:0];
                end
            end
            for (int i = 0; i < L; i++) begin
                if (v[i] && exp_rdy[i]) mq[i].push_back({a[i], d[i]});
            end
        end
        #1;
        valid_i = '0;
        flush_i = 1'b0;
    endtask

    task automatic idle(output logic [L-1:0] got_rdy, output logic [L-1:0] exp_rdy);
        run_cycle('0, '0, '0, 1'b0, got_rdy, exp_rdy);
    endtask

    task automatic test_reset();
        logic [L-1:0] gr, er;
        #1 arst_i = 1'b1;
        #1;
        tests_run++;
        if (ready_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_ready got %b exp %b", ready_o, 4'b1111);
        end
        tests_run++;
        if (dut_state() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %h exp 0", dut_state());
        end
        repeat (2) @(posedge clk_i);
        #1 arst_i = 1'b0;
        model_clear();
        idle(gr, er);
        tests_run++;
        if (gr !== 4'b1111 || dut_state() !== exp_state()) begin
            tests_failed++;
            $display("FAIL reset_release ready %b state %h exp %h", gr, dut_state(), exp_state());
        end
    endtask

    task automatic test_basic();
        logic [L-1:0]         gr, er;
        logic [L-1:0][AW-1:0] a;
        logic [L-1:0][WW-1:0] d;
        for (int i = 0; i < L; i++) begin
            a[i] = AW'(i);
            d[i] = WW'(i);
        end
        run_cycle(4'b1111, a, d, 1'b0, gr, er);
        tests_run++;
        if (gr !== er || dut_state() !== exp_state()) begin
            tests_failed++;
            $display("FAIL basic_accept ready %b/%b state %h exp %h", gr, er, dut_state(), exp_state());
        end
        idle(gr, er);
        tests_run++;
        if (enable_writing_o !== 4'b1111 || select_r_o !== a || data_o !== d) begin
            tests_failed++;
            $display("FAIL basic_write en %b sel %h data %h exp 1111 %h %h", enable_writing_o, select_r_o, data_o, a, d);
        end
        idle(gr, er);
        tests_run++;
        if ({rf[3], rf[2], rf[1], rf[0]} !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
            tests_failed++;
            $display("FAIL basic_regfile got %h %h %h %h exp 3 2 1 0", rf[3], rf[2], rf[1], rf[0]);
        end
    endtask

    task automatic test_conflict2();
        logic [L-1:0]         gr, er;
        logic [L-1:0][AW-1:0] a = '0;
        logic [L-1:0][WW-1:0] d = '0;
        a[0] = 5'd5; d[0] = 32'd7;
        a[2] = 5'd5; d[2] = 32'd9;
        run_cycle(4'b0101, a, d, 1'b0, gr, er);
        idle(gr, er);
        tests_run++;
        if (enable_writing_o !== 4'b0001 || dut_state() !== exp_state()) begin
            tests_failed++;
            $display("FAIL conflict2_first en %b state %h exp %h", enable_writing_o, dut_state(), exp_state());
        end
        idle(gr, er);
        tests_run++;
        if (enable_writing_o !== 4'b0100 || rf[5] !== 32'd7) begin
            tests_failed++;
            $display("FAIL conflict2_second en %b reg5 %0d exp 0100 7", enable_writing_o, rf[5]);
        end
        idle(gr, er);
        tests_run++;
        if (rf[5] !== 32'd9) begin
            tests_failed++;
            $display("FAIL conflict2_final reg5 got %0d exp 9", rf[5]);
        end
    endtask

    task automatic test_backpressure();
        logic [L-1:0]         gr, er;
        logic [L-1:0][AW-1:0] a = '0;
        logic [L-1:0][WW-1:0] d = '0;
        int n1;
        n1 = wlog[1].size();
        a[0] = 5'd4;
        a[1] = 5'd4;
        for (int k = 0; k < 4; k++) begin
            d[0] = WW'(200 + k);
            d[1] = WW'(100 + k);
            run_cycle(4'b0011, a, d, 1'b0, gr, er);
            tests_run++;
            if (gr[1] !== (k < 2) || gr !== er || dut_state() !== exp_state()) begin
                tests_failed++;
                $display("FAIL backpressure_c%0d ready %b/%b state %h exp %h", k, gr, er, dut_state(), exp_state());
            end
        end
        for (int k = 0; k < 6; k++) begin
            idle(gr, er);
            tests_run++;
            if (dut_state() !== exp_state()) begin
                tests_failed++;
                $display("FAIL backpressure_drain%0d state %h exp %h", k, dut_state(), exp_state());
            end
        end
        tests_run++;
        if (wlog[1].size() - n1 != 2 || wlog[1][n1] !== 32'd100 || wlog[1][n1+1] !== 32'd101 || rf[4] !== 32'd101) begin
            tests_failed++;
            $display("FAIL backpressure_writes lane1 count %0d reg4 %0d exp 2 101", wlog[1].size() - n1, rf[4]);
        end
    endtask

    task automatic test_flush();
        logic [L-1:0]         gr, er;
        logic [L-1:0][AW-1:0] a = '0;
        logic [L-1:0][WW-1:0] d = '0;
        int n3;
        n3 = wlog[3].size();
        a[0] = 5'd20;
        a[3] = 5'd20;
        for (int k = 0; k < 2; k++) begin
            d[0] = WW'(32'h11 + k);
            d[3] = WW'(32'hF1 + k);
            run_cycle(4'b1001, a, d, 1'b0, gr, er);
        end
        run_cycle(4'b1001, a, d, 1'b1, gr, er);
        tests_run++;
        if (gr !== 4'b0000 || pending_o[3] !== 1'b0 || dut_state() !== exp_state()) begin
            tests_failed++;
            $display("FAIL flush_cycle ready %b state %h exp %h", gr, dut_state(), exp_state());
        end
        tests_run++;
        if (rf[20] !== 32'h11) begin
            tests_failed++;
            $display("FAIL flush_inflight reg20 got %h exp 11", rf[20]);
        end
        repeat (3) idle(gr, er);
        tests_run++;
        if (rf[20] !== 32'h11 || wlog[3].size() != n3 || pending_o !== 4'b0000) begin
            tests_failed++;
            $display("FAIL flush_discard reg20 %h lane3 writes %0d pending %b exp 11 0 0000", rf[20], wlog[3].size() - n3, pending_o);
        end
    endtask

    task automatic test_async_reset();
        logic [L-1:0]         gr, er;
        logic [L-1:0][AW-1:0] a;
        logic [L-1:0][WW-1:0] d;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < L; i++) begin
                a[i] = AW'(8 + i);
                d[i] = $urandom;
            end
            run_cycle(4'b1111, a, d, 1'b0, gr, er);
        end
        tests_run++;
        if (enable_writing_o !== 4'b1111 || dut_state() !== exp_state()) begin
            tests_failed++;
            $display("FAIL areset_before en %b state %h exp %h", enable_writing_o, dut_state(), exp_state());
        end
        #2 arst_i = 1'b1;
        #1;
        model_clear();
        tests_run++;
        if (dut_state() !== '0 || ready_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL areset_immediate state %h ready %b exp 0 1111", dut_state(), ready_o);
        end
        @(posedge clk_i);
        #2 arst_i = 1'b0;
        idle(gr, er);
        tests_run++;
        if (gr !== 4'b1111 || dut_state() !== exp_state()) begin
            tests_failed++;
            $display("FAIL areset_release ready %b state %h exp %h", gr, dut_state(), exp_state());
        end
    endtask

    task automatic test_conflict4();
        logic [L-1:0]         gr, er;
        logic [L-1:0][AW-1:0] a;
        logic [L-1:0][WW-1:0] d;
        for (int i = 0; i < L; i++) begin
            a[i] = 5'd31;
            d[i] = WW'(10 + i);
        end
        run_cycle(4'b1111, a, d, 1'b0, gr, er);
        for (int k = 0; k < L; k++) begin
            idle(gr, er);
            tests_run++;
            if (enable_writing_o !== L'(1 << k) || data_o[k] !== WW'(10 + k)) begin
                tests_failed++;
                $display("FAIL conflict4_step%0d en %b data %0d exp %b %0d", k, enable_writing_o, data_o[k], L'(1 << k), 10 + k);
            end
        end
        idle(gr, er);
        tests_run++;
        if (rf[31] !== 32'd13) begin
            tests_failed++;
            $display("FAIL conflict4_final reg31 got %0d exp 13", rf[31]);
        end
    endtask

    task automatic test_random();
        logic [L-1:0]         gr, er;
        logic [L-1:0]         v;
        logic [L-1:0][AW-1:0] a;
        logic [L-1:0][WW-1:0] d;
        logic                 f;
        for (int k = 0; k < 400; k++) begin
            v = L'($urandom);
            for (int i = 0; i < L; i++) begin
                a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 3));
                d[i] = $urandom;
            end
            f = ($urandom_range(0, 19) == 0);
            run_cycle(v, a, d, f, gr, er);
            tests_run++;
            if (gr !== er || dut_state() !== exp_state()) begin
                tests_failed++;
                $display("FAIL random_c%0d ready %b/%b state %h exp %h", k, gr, er, dut_state(), exp_state());
            end
        end
        repeat (10) idle(gr, er);
        tests_run++;
        if (pending_o !== 4'b0000 || dut_state() !== exp_state()) begin
            tests_failed++;
            $display("FAIL random_drain pending %b state %h exp %h", pending_o, dut_state(), exp_state());
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_conflict2();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_conflict4();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
